irq_priority_ctrl: RTL and testbench

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_sync_edge.sv | 52 +++++
 rtl/irq_priority_ctrl.sv | 108 ++++++++++
 tb/tb_irq_priority_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt priority controller.
package irq_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StRequest   = 2'b01,
        StInService = 2'b10
    } irq_state_e;

    localparam int unsigned VEC_STRIDE      = 4;
    localparam int unsigned NUM_IRQ_DEFAULT = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchronizer, rising-edge detect and pending bit (edge or level mode).
module irq_sync_edge
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_src,
    input  logic i_edge_sel,
    input  logic i_clear,
    output logic o_pending
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_pending;
    logic w_rise;
    logic w_pending_d;

    assign w_rise = r_s2 & ~r_s3;

    // A new edge beats a coincident acknowledge so the second event is not lost.
    always_comb begin
        w_pending_d = r_pending;
        if (i_edge_sel) begin
            if (w_rise) begin
                w_pending_d = 1'b1;
            end else if (i_clear) begin
                w_pending_d = 1'b0;
            end
        end else begin
            w_pending_d = r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_s1      <= i_src;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_pending <= w_pending_d;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/irq_priority_ctrl.sv
// Fixed-priority interrupt controller: pending capture, request/acknowledge FSM and
// trap vector generation.
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int unsigned IDW     = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_edge_sel,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [XLEN-1:0]    vector_base,
    input  logic               vectored_mode,
    input  logic               irq_taken,
    input  logic               irq_complete,
    output logic               interrupt_pending,
    output logic [XLEN-1:0]    interrupt_vector,
    output logic [IDW-1:0]     active_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending_bits
);

    irq_state_e r_state;
    irq_state_e w_state_d;
    logic [IDW-1:0]     r_active_id;
    logic [IDW-1:0]     w_active_id_d;
    logic [IDW-1:0]     w_sel_id;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_masked;
    logic [NUM_IRQ-1:0] w_clear;
    logic [XLEN-1:0]    w_base_aligned;
    logic [XLEN-1:0]    w_offset;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
        // Acknowledge only clears the source currently being requested.
        assign w_clear[g] = irq_taken && (r_state == StRequest) && (r_active_id == IDW'(g));

        irq_sync_edge u_sync_edge (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_src      (irq_src[g]),
            .i_edge_sel (irq_edge_sel[g]),
            .i_clear    (w_clear[g]),
            .o_pending  (w_pending[g])
        );
    end

    assign w_masked = w_pending & irq_mask;

    // Scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        w_sel_id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_sel_id = IDW'(i);
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_active_id_d = r_active_id;
        unique case (r_state)
            StIdle: begin
                if (|w_masked) begin
                    w_state_d     = StRequest;
                    w_active_id_d = w_sel_id;
                end
            end
            StRequest: begin
                if (irq_taken) begin
                    w_state_d = StInService;
                end
            end
            StInService: begin
                if (irq_complete) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_active_id <= '0;
        end else begin
            r_state     <= w_state_d;
            r_active_id <= w_active_id_d;
        end
    end

    assign w_base_aligned = vector_base & ~XLEN'(3);
    assign w_offset       = vectored_mode ? XLEN'(r_active_id) * XLEN'(VEC_STRIDE) : '0;

    assign interrupt_vector  = w_base_aligned + w_offset;
    assign interrupt_pending = (r_state == StRequest);
    assign in_service        = (r_state == StInService);
    assign active_id         = r_active_id;
    assign pending_bits      = w_pending;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scoreboard bench for irq_priority_ctrl: expected requests are queued at stimulus time
// and checked when interrupt_pending rises.
module tb_irq_priority_ctrl;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned IDW     = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_edge_sel;
    logic [NUM_IRQ-1:0] irq_mask;
    logic [XLEN-1:0]    vector_base;
    logic               vectored_mode;
    logic               irq_taken;
    logic               irq_complete;
    logic               interrupt_pending;
    logic [XLEN-1:0]    interrupt_vector;
    logic [IDW-1:0]     active_id;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending_bits;

    typedef struct {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] vec;
        int              lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    irq_priority_ctrl #(
        .XLEN    (XLEN),
        .NUM_IRQ (NUM_IRQ),
        .IDW     (IDW)
    ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .irq_src           (irq_src),
        .irq_edge_sel      (irq_edge_sel),
        .irq_mask          (irq_mask),
        .vector_base       (vector_base),
        .vectored_mode     (vectored_mode),
        .irq_taken         (irq_taken),
        .irq_complete      (irq_complete),
        .interrupt_pending (interrupt_pending),
        .interrupt_vector  (interrupt_vector),
        .active_id         (active_id),
        .in_service        (in_service),
        .pending_bits      (pending_bits)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_src(input logic [NUM_IRQ-1:0] m);
        irq_src = irq_src | m;
        step();
        irq_src = irq_src & ~m;
    endtask

    task automatic push_exp(input int id, input logic [XLEN-1:0] vec, input int lat);
        exp_t e;
        e.id  = IDW'(id);
        e.vec = vec;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic await_request();
        exp_t e;
        int   cnt = 0;
        while (!interrupt_pending && cnt < 20) begin
            step();
            cnt++;
        end
        check_eq("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("req_seen", 64'(interrupt_pending), 64'd1);
            check_eq("req_id", 64'(active_id), 64'(e.id));
            check_eq("req_vec", 64'(interrupt_vector), 64'(e.vec));
            if (e.lat != 0) check_eq("req_latency", 64'(cnt), 64'(e.lat));
        end
    endtask

    task automatic service();
        irq_taken = 1'b1;
        step();
        irq_taken    = 1'b0;
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        irq_src       = '0;
        irq_edge_sel  = '1;
        irq_mask      = '1;
        vector_base   = 32'h8000_0003;
        vectored_mode = 1'b1;
        irq_taken     = 1'b0;
        irq_complete  = 1'b0;
        step();
        step();
        check_eq("rst_pending", 64'(interrupt_pending), 64'd0);
        check_eq("rst_in_service", 64'(in_service), 64'd0);
        check_eq("rst_active_id", 64'(active_id), 64'd0);
        check_eq("rst_pending_bits", 64'(pending_bits), 64'd0);
        check_eq("rst_vector_aligned", 64'(interrupt_vector), 64'h8000_0000);
        vector_base = 32'h8000_0000;
        rst_n       = 1'b1;
        step();

        // Edge on src 3: pending bit after 3 edges, request after the 4th.
        irq_src[3] = 1'b1;
        step();
        step();
        step();
        check_eq("lat_pending_bit3", 64'(pending_bits), 64'h08);
        check_eq("lat_not_yet_req", 64'(interrupt_pending), 64'd0);
        push_exp(3, 32'h8000_000C, 1);
        await_request();
        irq_src[3] = 1'b0;
        irq_taken  = 1'b1;
        step();
        irq_taken = 1'b0;
        check_eq("take3_pending_bits", 64'(pending_bits), 64'h00);
        check_eq("take3_in_service", 64'(in_service), 64'd1);
        check_eq("take3_req_drop", 64'(interrupt_pending), 64'd0);
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
        check_eq("cmpl3_in_service", 64'(in_service), 64'd0);
        repeat (5) step();
        check_eq("idle_no_req", 64'(interrupt_pending), 64'd0);

        // Simultaneous edges on 5 and 2: lower index first.
        pulse_src(8'h24);
        push_exp(2, 32'h8000_0008, 3);
        push_exp(5, 32'h8000_0014, 1);
        await_request();
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
        check_eq("cmpl_in_req_ignored", 64'(interrupt_pending), 64'd1);
        check_eq("cmpl_in_req_no_svc", 64'(in_service), 64'd0);
        irq_taken    = 1'b1;
        irq_complete = 1'b1;
        step();
        irq_taken    = 1'b0;
        irq_complete = 1'b0;
        check_eq("take_wins_in_service", 64'(in_service), 64'd1);
        check_eq("take_wins_req_drop", 64'(interrupt_pending), 64'd0);
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
        await_request();
        service();

        // Level src 1 held high through its handler.
        irq_edge_sel = 8'hFD;
        irq_src[1]   = 1'b1;
        push_exp(1, 32'h8000_0004, 4);
        await_request();
        irq_taken = 1'b1;
        step();
        irq_taken = 1'b0;
        check_eq("lvl_bit_after_take", 64'(pending_bits[1]), 64'd1);
        repeat (3) step();
        check_eq("lvl_bit_in_handler", 64'(pending_bits[1]), 64'd1);
        check_eq("lvl_no_req_in_svc", 64'(interrupt_pending), 64'd0);
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
        push_exp(1, 32'h8000_0004, 1);
        await_request();
        irq_src[1] = 1'b0;
        irq_taken  = 1'b1;
        step();
        irq_taken = 1'b0;
        repeat (3) step();
        check_eq("lvl_bit_follows_src", 64'(pending_bits[1]), 64'd0);
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
        repeat (3) step();
        check_eq("lvl_no_rereq", 64'(interrupt_pending), 64'd0);
        irq_edge_sel = '1;

        // Masked source keeps its pending bit but is not selected; no withdrawal.
        irq_mask = 8'hEF;
        pulse_src(8'h10);
        repeat (5) step();
        check_eq("mask_no_req", 64'(interrupt_pending), 64'd0);
        check_eq("mask_keeps_bit", 64'(pending_bits), 64'h10);
        irq_mask = '1;
        push_exp(4, 32'h8000_0010, 1);
        await_request();
        irq_mask = 8'hEF;
        step();
        step();
        check_eq("nowd_pending", 64'(interrupt_pending), 64'd1);
        check_eq("nowd_id", 64'(active_id), 64'd4);
        check_eq("nowd_vec", 64'(interrupt_vector), 64'h8000_0010);
        irq_mask = '1;
        service();
        check_eq("mask_bit_cleared", 64'(pending_bits), 64'h00);

        // New edge on src 0 coinciding with its acknowledge keeps it pending.
        pulse_src(8'h01);
        push_exp(0, 32'h8000_0000, 3);
        await_request();
        irq_src[0] = 1'b1;
        step();
        step();
        irq_taken = 1'b1;
        step();
        irq_taken  = 1'b0;
        irq_src[0] = 1'b0;
        check_eq("set_wins_svc", 64'(in_service), 64'd1);
        check_eq("set_wins_bit0", 64'(pending_bits[0]), 64'd1);
        irq_complete = 1'b1;
        step();
        irq_complete = 1'b0;
        push_exp(0, 32'h8000_0000, 1);
        await_request();
        service();
        check_eq("bit0_cleared", 64'(pending_bits[0]), 64'd0);

        // Vector alignment and silent wrap-around.
        vector_base   = 32'hFFFF_FFFF;
        vectored_mode = 1'b0;
        pulse_src(8'h80);
        push_exp(7, 32'hFFFF_FFFC, 3);
        await_request();
        vectored_mode = 1'b1;
        #1;
        check_eq("vec_wrap", 64'(interrupt_vector), 64'h0000_0018);
        service();
        vector_base = 32'h8000_0000;

        // Asynchronous reset in the middle of a handler.
        pulse_src(8'h04);
        push_exp(2, 32'h8000_0008, 3);
        await_request();
        irq_taken = 1'b1;
        step();
        irq_taken = 1'b0;
        check_eq("pre_rst_in_service", 64'(in_service), 64'd1);
        pulse_src(8'h40);
        repeat (3) step();
        check_eq("pre_rst_bit6", 64'(pending_bits[6]), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_in_service", 64'(in_service), 64'd0);
        check_eq("arst_pending", 64'(interrupt_pending), 64'd0);
        check_eq("arst_active_id", 64'(active_id), 64'd0);
        check_eq("arst_pending_bits", 64'(pending_bits), 64'd0);
        check_eq("arst_vector", 64'(interrupt_vector), 64'h8000_0000);
        step();
        rst_n = 1'b1;
        repeat (8) step();
        check_eq("post_rst_no_req", 64'(interrupt_pending), 64'd0);
        check_eq("post_rst_bits", 64'(pending_bits), 64'd0);

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
